// File: rtl/vend_datapath.sv
// Vending-machine datapath: coin accumulation, price check, vend strobe and
// greedy change payout over a valid/ready coin dispenser.
module vend_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic [1:0] sel,
  input  logic       ldM,
  input  logic       check,
  input  logic       RC,
  input  logic       canceled,
  input  logic       done,
  output logic       error,
  output logic [7:0] money,
  output logic       vend,
  output logic [1:0] vend_id,
  output logic       coin_out_valid,
  output logic [1:0] coin_out_val,
  input  logic       coin_out_ready,
  output logic       reject,
  output logic       payout_busy,
  output logic       payout_done,
  output logic [2:0] dp_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_EVAL   = 3'd2,
    S_PAYOUT = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  money_q, money_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  rem_q, rem_d;
  logic        vend_q, vend_d;
  logic [1:0]  vend_id_q, vend_id_d;
  logic        reject_q, reject_d;
  logic [8:0]  coin_sum;
  logic [7:0]  price_sel;
  logic [1:0]  denom;
  logic        coin_ok;
  // The controller's done strobe carries no datapath action; FIN waits for reset.
  logic        unused_done;

  function automatic logic [7:0] coin_amt(input logic [1:0] c);
    case (c)
      2'd0:    coin_amt = 8'd5;
      2'd1:    coin_amt = 8'd10;
      2'd2:    coin_amt = 8'd25;
      default: coin_amt = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    price_of = 8'd15;
      2'd1:    price_of = 8'd20;
      2'd2:    price_of = 8'd35;
      default: price_of = 8'd50;
    endcase
  endfunction

  assign unused_done = done;
  assign price_sel   = price_of(sel_q);
  assign coin_sum    = {1'b0, money_q} + {1'b0, coin_amt(coin_val)};
  assign coin_ok     = (state_q == S_ACCUM) && ldM && (coin_val != 2'd3) && !coin_sum[8];

  // Greedy denomination follows remaining, so it stays put while the dispenser stalls.
  always_comb begin
    denom = 2'd0;
    if (rem_q >= 8'd25)      denom = 2'd2;
    else if (rem_q >= 8'd10) denom = 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    money_d   = money_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    vend_d    = 1'b0;
    vend_id_d = vend_id_q;
    reject_d  = 1'b0;

    if (coin_valid) begin
      if (coin_ok) money_d  = coin_sum[7:0];
      else         reject_d = 1'b1;
    end

    if (ldM && (state_q == S_IDLE || state_q == S_ACCUM)) sel_d = sel;

    case (state_q)
      S_IDLE:  if (ldM) state_d = S_ACCUM;
      S_ACCUM: if (check) state_d = S_EVAL;
      S_EVAL: begin
        if (RC || canceled) begin
          money_d = 8'd0;
          if (canceled) begin
            rem_d = money_q;
          end else begin
            vend_d    = 1'b1;
            vend_id_d = sel_q;
            // Clamp rather than wrap if the controller vends without enough credit.
            rem_d = (money_q >= price_sel) ? (money_q - price_sel) : 8'd0;
          end
          state_d = (rem_d != 8'd0) ? S_PAYOUT : S_FIN;
        end
      end
      S_PAYOUT: begin
        if (coin_out_ready) begin
          rem_d = rem_q - coin_amt(denom);
          if (rem_d == 8'd0) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      money_q   <= 8'd0;
      sel_q     <= 2'd0;
      rem_q     <= 8'd0;
      vend_q    <= 1'b0;
      vend_id_q <= 2'd0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      money_q   <= money_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      vend_q    <= vend_d;
      vend_id_q <= vend_id_d;
      reject_q  <= reject_d;
    end
  end

  // Change handshake: a coin transfers on a cycle with coin_out_valid && coin_out_ready;
  // valid and value hold steady until that happens.
  assign coin_out_valid = (state_q == S_PAYOUT);
  assign coin_out_val   = coin_out_valid ? denom : 2'd0;
  assign error          = check && (money_q < price_sel);
  assign money          = money_q;
  assign vend           = vend_q;
  assign vend_id        = vend_id_q;
  assign reject         = reject_q;
  assign payout_busy    = (state_q == S_PAYOUT);
  assign payout_done    = (state_q == S_FIN);
  assign dp_state       = state_q;

endmodule
